// File: rtl/sata_dbg_pkg.sv
// Shared SATA debug definitions: trace-reader state encoding, probe width
// default and the bit offsets used when assembling the 192-bit probe word.
package sata_dbg_pkg;

    localparam int unsigned SATA_PROBE_W = 192;

    // Probe-word field offsets (same layout as the logic-analyzer trigger bus)
    localparam int unsigned PRB_RX_DATA_LSB    = 0;
    localparam int unsigned PRB_TX_DATA_LSB    = 32;
    localparam int unsigned PRB_RX_CTRL_LSB    = 64;
    localparam int unsigned PRB_TX_CTRL_LSB    = 96;
    localparam int unsigned PRB_LINK_STATE_LSB = 128;
    localparam int unsigned PRB_XPORT_STATE_LSB = 160;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } trc_state_e;

endpackage

// File: rtl/sata_trace_reader_if.sv
// 32-bit valid/ready readout stream of the trace buffer.
interface sata_trace_reader_if;

    logic [31:0] RdData;
    logic        RdValid;
    logic        RdReady;
    logic        RdLast;

    modport master (output RdData, output RdValid, output RdLast, input RdReady);
    modport slave  (input RdData, input RdValid, input RdLast, output RdReady);

endinterface

// File: rtl/sata_trace_ram.sv
// Simple dual-port trace RAM: write port A, registered read port B (1-cycle latency).
module sata_trace_ram #(
    parameter int unsigned C_W          = 192,
    parameter int unsigned C_DEPTH_LOG2 = 9
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [C_DEPTH_LOG2-1:0] wr_addr,
    input  logic [C_W-1:0]          wr_data,
    input  logic                    re,
    input  logic [C_DEPTH_LOG2-1:0] rd_addr,
    output logic [C_W-1:0]          rd_data
);

    logic [C_W-1:0] mem [2**C_DEPTH_LOG2];

    // Block-RAM style write and registered read; contents have no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sata_trace_reader.sv
// Circular pre/post-trigger trace buffer for SATA debug with a 32-bit
// valid/ready readout stream (oldest entry first, word 0 = bits [31:0]).
module sata_trace_reader
    import sata_dbg_pkg::*;
#(
    parameter int unsigned C_DEPTH_LOG2 = 9,
    parameter int unsigned C_PROBE_W    = SATA_PROBE_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [C_PROBE_W-1:0]    TRIG0,
    input  logic                    TrigIn,
    input  logic                    Arm,
    input  logic [C_DEPTH_LOG2-1:0] PostCnt,
    input  logic                    RdStart,
    output logic                    Armed,
    output logic                    Triggered,
    output logic                    Done,
    output logic [C_DEPTH_LOG2:0]   Entries,
    output logic [C_DEPTH_LOG2-1:0] TrigPos,
    sata_trace_reader_if.master     rd
);

    localparam int unsigned C_WORDS = C_PROBE_W / 32;
    localparam int unsigned DL      = C_DEPTH_LOG2;
    localparam int unsigned EW      = C_DEPTH_LOG2 + 1;
    localparam int unsigned KW      = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
    localparam int unsigned C_DEPTH = 1 << C_DEPTH_LOG2;

    // FSM
    trc_state_e state_q, state_d;
    logic       armed_q, armed_d;
    logic       done_q, done_d;

    // Capture side
    logic [DL-1:0] wr_ptr_q, wr_ptr_d;
    logic [EW-1:0] entries_q, entries_d;
    logic [DL-1:0] post_q, post_d;
    logic [DL-1:0] remaining_q, remaining_d;
    logic          triggered_q, triggered_d;
    logic [DL-1:0] trig_pos_q, trig_pos_d;
    logic [EW-1:0] trig_full_s;
    logic          arm_accept_s;
    logic          we_s;

    // Readout side: request generator, RAM stage, skid, output register
    logic [DL-1:0]    rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    ent_left_q, ent_left_d;
    logic [KW-1:0]    word_k_q, word_k_d;
    logic             issue_done_q, issue_done_d;
    logic             p_valid_q, p_valid_d;
    logic [KW-1:0]    p_k_q, p_k_d;
    logic             p_last_q, p_last_d;
    logic [31:0]      skid_data_q [2];
    logic [31:0]      skid_data_d [2];
    logic             skid_last_q [2];
    logic             skid_last_d [2];
    logic [1:0]       skid_cnt_q, skid_cnt_d;
    logic [1:0]       skid_after_s;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             rd_start_s;
    logic             issue_s;
    logic             last_req_s;
    logic             acc_s;
    logic             out_free_s;
    logic             push_s;
    logic [2:0]       occ_s;
    logic [31:0]      arr_data_s;
    logic [C_PROBE_W-1:0] ram_dout_s;

    sata_trace_ram #(
        .C_W          (C_PROBE_W),
        .C_DEPTH_LOG2 (C_DEPTH_LOG2)
    ) u_ram (
        .clk     (CLK),
        .we      (we_s),
        .wr_addr (wr_ptr_q),
        .wr_data (TRIG0),
        .re      (issue_s),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_dout_s)
    );

    assign arm_accept_s = Arm && (state_q != ST_READ);
    assign rd_start_s   = (state_q == ST_DONE) && RdStart && !Arm;
    assign acc_s        = out_valid_q && rd.RdReady;
    assign out_free_s   = !out_valid_q || rd.RdReady;
    assign last_req_s   = (ent_left_q == EW'(1)) && (word_k_q == KW'(C_WORDS - 1));
    // Storage is out reg + 2 skid slots; only issue if the word will have room on arrival
    assign occ_s        = 3'({2'b00, p_valid_q}) + 3'({1'b0, skid_cnt_q})
                        + 3'({2'b00, out_valid_q}) - 3'({2'b00, acc_s});
    assign issue_s      = (state_q == ST_READ) && !issue_done_q && (occ_s <= 3'd2);
    assign arr_data_s   = ram_dout_s[{p_k_q, 5'b00000} +: 32];

    // FSM state register and registered status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    // FSM next-state logic; Arm takes priority over a same-cycle trigger or RdStart
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Arm) state_d = ST_ARMED;
                else     state_d = ST_IDLE;
            end
            ST_ARMED: begin
                if (Arm)                state_d = ST_ARMED;
                else if (!TrigIn)       state_d = ST_ARMED;
                else if (post_q == '0)  state_d = ST_DONE;
                else                    state_d = ST_POST;
            end
            ST_POST: begin
                if (Arm)                          state_d = ST_ARMED;
                else if (remaining_q == DL'(1))   state_d = ST_DONE;
                else                              state_d = ST_POST;
            end
            ST_DONE: begin
                if (Arm)          state_d = ST_ARMED;
                else if (RdStart) state_d = ST_READ;
                else              state_d = ST_DONE;
            end
            ST_READ: begin
                if (acc_s && out_last_q) state_d = ST_DONE;
                else                     state_d = ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: status flags from the next state, RAM write enable from current state
    always_comb begin
        armed_d = (state_d == ST_ARMED) || (state_d == ST_POST);
        done_d  = (state_d == ST_DONE);
        we_s    = ((state_q == ST_ARMED) || (state_q == ST_POST)) && !Arm;
    end

    // Capture datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            entries_q   <= '0;
            post_q      <= '0;
            remaining_q <= '0;
            triggered_q <= 1'b0;
            trig_pos_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            entries_q   <= entries_d;
            post_q      <= post_d;
            remaining_q <= remaining_d;
            triggered_q <= triggered_d;
            trig_pos_q  <= trig_pos_d;
        end
    end

    // Capture: write pointer, fill count, post-trigger countdown, trigger position
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        entries_d   = entries_q;
        post_d      = post_q;
        remaining_d = remaining_q;
        triggered_d = triggered_q;
        trig_pos_d  = trig_pos_q;
        trig_full_s = '0;
        if (arm_accept_s) begin
            wr_ptr_d    = '0;
            entries_d   = '0;
            // PostCnt is DL bits wide, so it can never exceed depth-1
            post_d      = PostCnt;
            remaining_d = '0;
            triggered_d = 1'b0;
            trig_pos_d  = '0;
        end else if (we_s) begin
            wr_ptr_d = wr_ptr_q + DL'(1);
            if (entries_q == EW'(C_DEPTH)) entries_d = entries_q;
            else                           entries_d = entries_q + EW'(1);
            if (state_q == ST_ARMED && TrigIn) begin
                triggered_d = 1'b1;
                remaining_d = post_q;
            end else if (state_q == ST_POST) begin
                remaining_d = remaining_q - DL'(1);
            end else begin
                remaining_d = remaining_q;
            end
            trig_full_s = entries_d - {1'b0, post_q} - EW'(1);
            if (state_d == ST_DONE) trig_pos_d = trig_full_s[DL-1:0];
            else                    trig_pos_d = trig_pos_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Readout datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q     <= '0;
            ent_left_q   <= '0;
            word_k_q     <= '0;
            issue_done_q <= 1'b1;
            p_valid_q    <= 1'b0;
            p_k_q        <= '0;
            p_last_q     <= 1'b0;
            skid_data_q  <= '{32'h0, 32'h0};
            skid_last_q  <= '{1'b0, 1'b0};
            skid_cnt_q   <= 2'd0;
            out_data_q   <= 32'h0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            ent_left_q   <= ent_left_d;
            word_k_q     <= word_k_d;
            issue_done_q <= issue_done_d;
            p_valid_q    <= p_valid_d;
            p_k_q        <= p_k_d;
            p_last_q     <= p_last_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_cnt_q   <= skid_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    // Word request generator: walks entries oldest-first, C_WORDS words each
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        ent_left_d   = ent_left_q;
        word_k_d     = word_k_q;
        issue_done_d = issue_done_q;
        p_valid_d    = issue_s;
        p_k_d        = word_k_q;
        p_last_d     = issue_s && last_req_s;
        if (rd_start_s) begin
            rd_ptr_d     = wr_ptr_q - entries_q[DL-1:0];
            ent_left_d   = entries_q;
            word_k_d     = '0;
            issue_done_d = 1'b0;
        end else if (issue_s) begin
            if (word_k_q == KW'(C_WORDS - 1)) begin
                word_k_d   = '0;
                rd_ptr_d   = rd_ptr_q + DL'(1);
                ent_left_d = ent_left_q - EW'(1);
            end else begin
                word_k_d   = word_k_q + KW'(1);
            end
            issue_done_d = last_req_s;
        end else begin
            issue_done_d = issue_done_q;
        end
    end

    // Output register fed from the skid first, else straight from the RAM stage
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_after_s = skid_cnt_q;
        if (out_free_s) begin
            if (skid_cnt_q != 2'd0) begin
                out_data_d     = skid_data_q[0];
                out_last_d     = skid_last_q[0];
                out_valid_d    = 1'b1;
                skid_data_d[0] = skid_data_q[1];
                skid_last_d[0] = skid_last_q[1];
                skid_after_s   = skid_cnt_q - 2'd1;
            end else if (p_valid_q) begin
                out_data_d  = arr_data_s;
                out_last_d  = p_last_q;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        push_s = p_valid_q && !(out_free_s && (skid_cnt_q == 2'd0));
        if (push_s) begin
            if (skid_after_s == 2'd0) begin
                skid_data_d[0] = arr_data_s;
                skid_last_d[0] = p_last_q;
            end else begin
                skid_data_d[1] = arr_data_s;
                skid_last_d[1] = p_last_q;
            end
        end else begin
            skid_after_s = skid_after_s;
        end
        skid_cnt_d = skid_after_s + {1'b0, push_s};
    end

    assign Armed      = armed_q;
    assign Done       = done_q;
    assign Triggered  = triggered_q;
    assign Entries    = entries_q;
    assign TrigPos    = trig_pos_q;
    assign rd.RdData  = out_data_q;
    assign rd.RdValid = out_valid_q;
    assign rd.RdLast  = out_last_q;

endmodule
